unit_bram_sequencer: RTL and testbench

- Parametrised BRAM-to-compute-unit sequencer; successor to the fixed two-phase BRAM test harness.
- Runs one vector command per start pulse: streams LEN entries from three source BRAMs (a, b, c) starting at SRC_BASE into an external compute unit. Results are written to a destination BRAM starting at DST_BASE.
- Opmode is programmable per command.
- Tolerates any compute-unit latency by counting unit_out_valid.
- Reports busy, done and error status to a host controller.

---
 rtl/unit_bram_sequencer_if.sv | 54 +++++
 rtl/unit_bram_sequencer.sv | 178 +++++++++++++++++
 tb/tb_unit_bram_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/unit_bram_sequencer_if.sv
// ============================================================================
// Module      : unit_bram_sequencer_if
// Description : Host command, BRAM and compute-unit signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface unit_bram_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256,
    parameter int BRAM_W = 288,
    parameter int WE_W   = 36,
    parameter int OP_W   = 8
) ();
    logic              start;
    logic [OP_W-1:0]   cmd_opmode;
    logic [ADDR_W-1:0] cmd_src_base;
    logic [ADDR_W-1:0] cmd_dst_base;
    logic [ADDR_W:0]   cmd_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] src_addr;
    logic [BRAM_W-1:0] src_a_rdata;
    logic [BRAM_W-1:0] src_b_rdata;
    logic [BRAM_W-1:0] src_c_rdata;
    logic [WE_W-1:0]   src_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [BRAM_W-1:0] dst_wdata;
    logic [WE_W-1:0]   dst_we;
    logic              unit_in_valid;
    logic [DATA_W-1:0] unit_a;
    logic [DATA_W-1:0] unit_b;
    logic [DATA_W-1:0] unit_c;
    logic [OP_W-1:0]   unit_opmode;
    logic [DATA_W-1:0] unit_out;
    logic              unit_out_valid;

    modport master (
        input  start, cmd_opmode, cmd_src_base, cmd_dst_base, cmd_len,
        input  src_a_rdata, src_b_rdata, src_c_rdata, unit_out, unit_out_valid,
        output busy, done, err, src_addr, src_we, dst_addr, dst_wdata, dst_we,
        output unit_in_valid, unit_a, unit_b, unit_c, unit_opmode
    );

    modport slave (
        output start, cmd_opmode, cmd_src_base, cmd_dst_base, cmd_len,
        output src_a_rdata, src_b_rdata, src_c_rdata, unit_out, unit_out_valid,
        input  busy, done, err, src_addr, src_we, dst_addr, dst_wdata, dst_we,
        input  unit_in_valid, unit_a, unit_b, unit_c, unit_opmode
    );
endinterface

`default_nettype wire

// File: rtl/unit_bram_sequencer.sv
// ============================================================================
// Module      : unit_bram_sequencer
// Description : Streams LEN operand triples from three BRAMs into a compute
//               unit and writes its results back to a destination BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unit_bram_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256,
    parameter int BRAM_W = 288,
    parameter int WE_W   = 36,
    parameter int RD_LAT = 1,
    parameter int OP_W   = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    unit_bram_sequencer_if.master bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [OP_W-1:0]   r_opmode;
    logic [ADDR_W-1:0] r_src_base;
    logic [ADDR_W-1:0] r_dst_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_wr_cnt;
    logic              r_issue;
    logic [RD_LAT-1:0] r_pipe;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [BRAM_W-1:0] r_dst_wdata;
    logic [WE_W-1:0]   r_dst_we;

    logic w_accept;
    logic w_wb_window;
    logic w_write;
    logic w_unexpected;

    assign w_accept     = (r_state == c_IDLE) && bus.start;
    // Results are only owed while a command is active and short of its length.
    assign w_wb_window  = ((r_state == c_ISSUE) || (r_state == c_DRAIN)) && (r_wr_cnt < r_len);
    assign w_write      = bus.unit_out_valid && w_wb_window;
    assign w_unexpected = bus.unit_out_valid && !w_wb_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_opmode    <= '0;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_issue     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_src_addr  <= '0;
            r_dst_addr  <= '0;
            r_dst_wdata <= '0;
            r_dst_we    <= '0;
        end else begin
            r_done   <= 1'b0;
            r_dst_we <= '0;

            if (w_write) begin
                r_dst_addr  <= r_dst_base + r_wr_cnt[ADDR_W-1:0];
                r_dst_wdata <= BRAM_W'(bus.unit_out);
                r_dst_we    <= '1;
                r_wr_cnt    <= r_wr_cnt + 1'b1;
            end

            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_unexpected) begin
                r_err <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_opmode   <= bus.cmd_opmode;
                        r_src_base <= bus.cmd_src_base;
                        r_dst_base <= bus.cmd_dst_base;
                        r_len      <= bus.cmd_len;
                        r_wr_cnt   <= '0;
                        if (bus.cmd_len != '0) begin
                            // First address goes out with the accept so reads start at T+1.
                            r_src_addr <= bus.cmd_src_base;
                            r_issue    <= 1'b1;
                            r_rd_cnt   <= {{ADDR_W{1'b0}}, 1'b1};
                            r_busy     <= 1'b1;
                            r_state    <= c_ISSUE;
                        end else begin
                            r_rd_cnt <= '0;
                            r_done   <= 1'b1;
                            r_state  <= c_DONE;
                        end
                    end
                end
                c_ISSUE: begin
                    if (r_rd_cnt == r_len) begin
                        r_issue <= 1'b0;
                        r_state <= c_DRAIN;
                    end else begin
                        r_src_addr <= r_src_base + r_rd_cnt[ADDR_W-1:0];
                        r_rd_cnt   <= r_rd_cnt + 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (r_wr_cnt == r_len) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Issue flag delayed by the BRAM read latency marks valid operands.
    if (RD_LAT == 1) begin : g_pipe_1
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= r_issue;
            end
        end
    end else begin : g_pipe_n
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[RD_LAT-2:0], r_issue};
            end
        end
    end

    if (BRAM_W > DATA_W) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^{bus.src_a_rdata[BRAM_W-1:DATA_W],
                                bus.src_b_rdata[BRAM_W-1:DATA_W],
                                bus.src_c_rdata[BRAM_W-1:DATA_W]};
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.src_addr      = r_src_addr;
    assign bus.src_we        = '0;
    assign bus.dst_addr      = r_dst_addr;
    assign bus.dst_wdata     = r_dst_wdata;
    assign bus.dst_we        = r_dst_we;
    assign bus.unit_in_valid = r_pipe[RD_LAT-1];
    assign bus.unit_a        = bus.src_a_rdata[DATA_W-1:0];
    assign bus.unit_b        = bus.src_b_rdata[DATA_W-1:0];
    assign bus.unit_c        = bus.src_c_rdata[DATA_W-1:0];
    assign bus.unit_opmode   = r_opmode;

endmodule

`default_nettype wire

// File: tb/tb_unit_bram_sequencer.sv
// ============================================================================
// Module      : tb_unit_bram_sequencer
// Description : Directed bench with BRAM models and a 3-cycle compute unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unit_bram_sequencer;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 256;
    localparam int BRAM_W = 288;
    localparam int WE_W   = 36;
    localparam int RD_LAT = 1;
    localparam int OP_W   = 8;

    logic clk;
    logic rst;
    logic inject;
    int   checks;
    int   errors;
    int   cyc;
    int   uiv_cnt;
    int   done_cnt;
    int   t0;
    int   wbase;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [BRAM_W-1:0] wq_data[$];
    int                wq_cyc[$];

    logic              v0, v1, v2;
    logic [DATA_W-1:0] d0, d1, d2;

    unit_bram_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_W(BRAM_W),
                             .WE_W(WE_W), .OP_W(OP_W)) bus ();

    unit_bram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_W(BRAM_W),
                          .WE_W(WE_W), .RD_LAT(RD_LAT), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [DATA_W-1:0] fa(input logic [ADDR_W-1:0] x);
        return DATA_W'(x) + 256'h1000;
    endfunction
    function automatic logic [DATA_W-1:0] fb(input logic [ADDR_W-1:0] x);
        return DATA_W'(x) << 8;
    endfunction
    function automatic logic [DATA_W-1:0] fc(input logic [ADDR_W-1:0] x);
        return {x, 246'd0} ^ 256'hC0DE_0000;
    endfunction
    function automatic logic [BRAM_W-1:0] res(input logic [ADDR_W-1:0] x);
        return {32'd0, fa(x) + fb(x) + fc(x)};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source BRAMs, one-cycle read; upper pad bits are junk the DUT must drop.
    always @(posedge clk) begin
        bus.src_a_rdata <= {32'hDEADBEEF, fa(bus.src_addr)};
        bus.src_b_rdata <= {32'hDEADBEEF, fb(bus.src_addr)};
        bus.src_c_rdata <= {32'hDEADBEEF, fc(bus.src_addr)};
    end

    always @(posedge clk) begin
        if (!rst) begin
            v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
            d0 <= '0;   d1 <= '0;   d2 <= '0;
        end else begin
            v0 <= bus.unit_in_valid; d0 <= bus.unit_a + bus.unit_b + bus.unit_c;
            v1 <= v0;                d1 <= d0;
            v2 <= v1;                d2 <= d1;
        end
    end
    assign bus.unit_out       = d2;
    assign bus.unit_out_valid = v2 | inject;

    task automatic chk(input string tag, input logic [BRAM_W-1:0] obs, input logic [BRAM_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.unit_in_valid) uiv_cnt++;
        if (bus.done) done_cnt++;
        if (bus.dst_we != '0) begin
            wq_addr.push_back(bus.dst_addr);
            wq_data.push_back(bus.dst_wdata);
            wq_cyc.push_back(cyc);
            chk("dst_we_full", BRAM_W'(bus.dst_we), BRAM_W'({WE_W{1'b1}}));
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 60) begin
            tick();
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $error("FAIL %s timeout observed=no_done expected=done", tag);
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [ADDR_W:0] len, input logic [OP_W-1:0] op);
        bus.cmd_src_base = src;
        bus.cmd_dst_base = dst;
        bus.cmd_len      = len;
        bus.cmd_opmode   = op;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; uiv_cnt = 0; done_cnt = 0;
        rst = 1'b0; inject = 1'b0;
        bus.start = 1'b0; bus.cmd_src_base = '0; bus.cmd_dst_base = '0;
        bus.cmd_len = '0; bus.cmd_opmode = '0;
        repeat (3) tick();
        chk("rst_busy", BRAM_W'(bus.busy), 0);
        chk("rst_done", BRAM_W'(bus.done), 0);
        chk("rst_err", BRAM_W'(bus.err), 0);
        chk("rst_uiv", BRAM_W'(bus.unit_in_valid), 0);
        chk("rst_src_addr", BRAM_W'(bus.src_addr), 0);
        chk("rst_dst_addr", BRAM_W'(bus.dst_addr), 0);
        chk("rst_dst_wdata", bus.dst_wdata, 0);
        chk("rst_dst_we", BRAM_W'(bus.dst_we), 0);
        chk("rst_opmode", BRAM_W'(bus.unit_opmode), 0);
        chk("src_we", BRAM_W'(bus.src_we), 0);
        rst = 1'b1;
        repeat (2) tick();

        // Basic command: src 0, dst 0x100, len 4, opmode 0x80
        wbase = wq_addr.size();
        issue(10'h000, 10'h100, 11'd4, 8'h80);
        t0 = cyc;
        chk("t1_src_addr", BRAM_W'(bus.src_addr), 0);
        chk("t1_busy", BRAM_W'(bus.busy), 1);
        chk("t1_uiv", BRAM_W'(bus.unit_in_valid), 0);
        chk("t1_opmode", BRAM_W'(bus.unit_opmode), 8'h80);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_src_addr_seq", BRAM_W'(bus.src_addr), BRAM_W'(i));
            chk("t1_uiv_on", BRAM_W'(bus.unit_in_valid), 1);
            chk("t1_unit_a", BRAM_W'(bus.unit_a), BRAM_W'(fa(10'(i - 1))));
        end
        tick();
        chk("t1_uiv_last", BRAM_W'(bus.unit_in_valid), 1);
        chk("t1_unit_c_last", BRAM_W'(bus.unit_c), BRAM_W'(fc(10'd3)));
        tick();
        chk("t1_uiv_off", BRAM_W'(bus.unit_in_valid), 0);
        wait_done("t1_done");
        chk("t1_done_cycle", BRAM_W'(cyc), BRAM_W'(t0 + 9));
        chk("t1_busy_at_done", BRAM_W'(bus.busy), 0);
        chk("t1_nwrites", BRAM_W'(wq_addr.size() - wbase), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_waddr", BRAM_W'(wq_addr[wbase + i]), BRAM_W'(10'h100 + i));
            chk("t1_wdata", wq_data[wbase + i], res(10'(i)));
            chk("t1_wcyc", BRAM_W'(wq_cyc[wbase + i]), BRAM_W'(t0 + 5 + i));
        end
        tick();
        chk("t1_done_pulse", BRAM_W'(bus.done), 0);
        chk("t1_err", BRAM_W'(bus.err), 0);

        // Zero-length command
        wbase = wq_addr.size();
        t0 = uiv_cnt;
        issue(10'h055, 10'h066, 11'd0, 8'h01);
        chk("len0_done", BRAM_W'(bus.done), 1);
        chk("len0_busy", BRAM_W'(bus.busy), 0);
        tick();
        chk("len0_done_off", BRAM_W'(bus.done), 0);
        repeat (4) tick();
        chk("len0_no_reads", BRAM_W'(uiv_cnt - t0), 0);
        chk("len0_no_writes", BRAM_W'(wq_addr.size() - wbase), 0);
        chk("len0_err", BRAM_W'(bus.err), 0);

        // Address wrap on both sides
        wbase = wq_addr.size();
        issue(10'h3FE, 10'h3FF, 11'd3, 8'h02);
        chk("wrap_rd0", BRAM_W'(bus.src_addr), 10'h3FE);
        tick();
        chk("wrap_rd1", BRAM_W'(bus.src_addr), 10'h3FF);
        tick();
        chk("wrap_rd2", BRAM_W'(bus.src_addr), 10'h000);
        wait_done("wrap_done");
        chk("wrap_nwrites", BRAM_W'(wq_addr.size() - wbase), 3);
        chk("wrap_wa0", BRAM_W'(wq_addr[wbase]), 10'h3FF);
        chk("wrap_wa1", BRAM_W'(wq_addr[wbase + 1]), 10'h000);
        chk("wrap_wa2", BRAM_W'(wq_addr[wbase + 2]), 10'h001);
        chk("wrap_wd0", wq_data[wbase], res(10'h3FE));
        chk("wrap_wd2", wq_data[wbase + 2], res(10'h000));
        tick();

        // Second start while busy is ignored
        wbase = wq_addr.size();
        issue(10'h010, 10'h020, 11'd5, 8'h11);
        tick();
        bus.cmd_src_base = 10'h200; bus.cmd_dst_base = 10'h300;
        bus.cmd_len = 11'd2; bus.cmd_opmode = 8'h22; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_start_src_addr", BRAM_W'(bus.src_addr), 10'h012);
        chk("busy_start_opmode", BRAM_W'(bus.unit_opmode), 8'h11);
        wait_done("busy_start_done");
        chk("busy_start_nwrites", BRAM_W'(wq_addr.size() - wbase), 5);
        chk("busy_start_last_addr", BRAM_W'(wq_addr[wbase + 4]), 10'h024);
        chk("busy_start_last_data", wq_data[wbase + 4], res(10'h014));
        chk("busy_start_opmode_held", BRAM_W'(bus.unit_opmode), 8'h11);

        // Extra result during DONE: not written, err sticks until next start
        wbase = wq_addr.size();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("extra_err", BRAM_W'(bus.err), 1);
        chk("extra_no_we", BRAM_W'(bus.dst_we), 0);
        repeat (3) tick();
        chk("extra_err_sticky", BRAM_W'(bus.err), 1);
        chk("extra_no_write", BRAM_W'(wq_addr.size() - wbase), 0);
        issue(10'h005, 10'h006, 11'd1, 8'h33);
        chk("extra_err_cleared", BRAM_W'(bus.err), 0);
        wait_done("extra_done");
        chk("extra_next_addr", BRAM_W'(wq_addr[wbase]), 10'h006);
        chk("extra_next_data", wq_data[wbase], res(10'h005));
        chk("extra_next_err", BRAM_W'(bus.err), 0);
        tick();

        // Reset in DRAIN after 2 of 5 results
        wbase = wq_addr.size();
        issue(10'h040, 10'h080, 11'd5, 8'h44);
        for (int n = 0; n < 40 && (wq_addr.size() - wbase) < 2; n++) tick();
        chk("rst_mid_two_written", BRAM_W'(wq_addr.size() - wbase), 2);
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", BRAM_W'(bus.busy), 0);
        chk("rst_mid_dst_we", BRAM_W'(bus.dst_we), 0);
        chk("rst_mid_dst_addr", BRAM_W'(bus.dst_addr), 0);
        chk("rst_mid_dst_wdata", bus.dst_wdata, 0);
        chk("rst_mid_src_addr", BRAM_W'(bus.src_addr), 0);
        chk("rst_mid_opmode", BRAM_W'(bus.unit_opmode), 0);
        chk("rst_mid_uiv", BRAM_W'(bus.unit_in_valid), 0);
        t0 = done_cnt;
        repeat (2) tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("rst_mid_no_done", BRAM_W'(done_cnt - t0), 0);
        chk("rst_mid_no_more_writes", BRAM_W'(wq_addr.size() - wbase), 2);
        chk("rst_mid_err", BRAM_W'(bus.err), 0);
        wbase = wq_addr.size();
        issue(10'h050, 10'h090, 11'd2, 8'h55);
        wait_done("rst_mid_new_done");
        chk("rst_mid_new_nwrites", BRAM_W'(wq_addr.size() - wbase), 2);
        chk("rst_mid_new_wa0", BRAM_W'(wq_addr[wbase]), 10'h090);
        chk("rst_mid_new_wa1", BRAM_W'(wq_addr[wbase + 1]), 10'h091);
        chk("rst_mid_new_wd1", wq_data[wbase + 1], res(10'h051));
        chk("rst_mid_new_err", BRAM_W'(bus.err), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
